eeg_loader: RTL and testbench

Front-end stage of the centralized CIM that accepts the 3840 raw 16-bit ADC samples of one inference window, converts each to double-width fixed point, and writes them into intermediate-result memory starting at `mem_map[EEG_INPUT_MEM]`. It runs during the `EEG_LOAD` state of the top-level FSM. The `PATCH_PROJ_STEP` of inference consumes the region it fills.

---
 rtl/eeg_loader_pkg.sv | 35 +++
 rtl/eeg_loader_if.sv | 27 ++
 rtl/eeg_loader_adc_to_fx.sv | 27 ++
 rtl/eeg_loader.sv | 82 ++++++++
 tb/tb_eeg_loader.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/eeg_loader_pkg.sv
// Shared types and constants for the EEG input loader and its memory interface.
// The EEG_LOADER_MIDSCALE_OFFSET_EN macro (see adc_to_fx) selects signed mid-scale conversion.
package eeg_loader_pkg;

  localparam int NUM_PATCHES          = 60;
  localparam int PATCH_LEN            = 64;
  localparam int NUM_EEG_SAMPLES      = NUM_PATCHES * PATCH_LEN;
  localparam int ADC_MIDSCALE         = 32768;
  localparam int Q_STO_INT_RES_DOUBLE = 20;
  localparam int CNT_W                = 12;

  typedef logic [15:0]        AdcData_t;
  typedef logic [15:0]        IntResAddr_t;
  typedef logic signed [29:0] IntResDouble_t;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } EegLoaderState_t;

  typedef enum int {
    EEG_INPUT_MEM  = 0,
    PATCH_PROJ_MEM = 1
  } MemRegion_t;

  // Element base address of each intermediate-result region.
  localparam int mem_map [2] = '{0, NUM_EEG_SAMPLES};

endpackage

// File: rtl/eeg_loader_if.sv
// ADC sample handshake plus intermediate-result memory write port of the EEG loader.
interface eeg_loader_if
  import eeg_loader_pkg::*;
();

  logic          start;
  logic          eeg_valid;
  AdcData_t      eeg_data;
  logic          eeg_ready;
  logic          wr_en;
  IntResAddr_t   wr_addr;
  IntResDouble_t wr_data;
  DataWidth_t    wr_width;
  logic          busy;
  logic          done;

  modport master (
    output start, eeg_valid, eeg_data,
    input  eeg_ready, wr_en, wr_addr, wr_data, wr_width, busy, done
  );

  modport slave (
    input  start, eeg_valid, eeg_data,
    output eeg_ready, wr_en, wr_addr, wr_data, wr_width, busy, done
  );

endinterface

// File: rtl/eeg_loader_adc_to_fx.sv
// Combinational ADC sample to Q20 double-width conversion.
// EEG_LOADER_MIDSCALE_OFFSET_EN: signed (x-32768)/2^15; otherwise unsigned x/2^16.
module adc_to_fx
  import eeg_loader_pkg::*;
(
  input  AdcData_t      sample,
  output IntResDouble_t fx
);

`ifdef EEG_LOADER_MIDSCALE_OFFSET_EN
  function automatic IntResDouble_t to_fx(input AdcData_t s);
    logic signed [16:0] centred;
    logic signed [21:0] scaled;
    centred = $signed({1'b0, s}) - $signed(17'(ADC_MIDSCALE));
    // 22 significant bits at most, so the widening never saturates.
    scaled  = 22'(centred) <<< 5;
    return IntResDouble_t'(scaled);
  endfunction
`else
  function automatic IntResDouble_t to_fx(input AdcData_t s);
    return IntResDouble_t'({s, 4'b0000});
  endfunction
`endif

  assign fx = to_fx(sample);

endmodule

// File: rtl/eeg_loader.sv
// Loads one window of raw ADC samples into intermediate-result memory as Q20 words.
// Conversion flavour follows EEG_LOADER_MIDSCALE_OFFSET_EN (resolved in adc_to_fx).
module eeg_loader
  import eeg_loader_pkg::*;
#(
  parameter int NUM_SAMPLES = NUM_EEG_SAMPLES,
  parameter int BASE_ADDR   = mem_map[EEG_INPUT_MEM]
) (
  input  logic         clk,
  input  logic         rst,
  eeg_loader_if.slave  bus
);

  localparam IntResAddr_t       BASE     = IntResAddr_t'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_SAMPLES - 1);

  EegLoaderState_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept_p0;
  logic             last_p0;
  IntResDouble_t    fx_p0;

  logic             vld_p1;
  IntResAddr_t      wr_addr_p1;
  IntResDouble_t    wr_data_p1;

  assign accept_p0 = bus.eeg_valid & (state_q == LOAD);
  assign last_p0   = accept_p0 && (cnt_q == LAST_CNT);

  adc_to_fx u_adc_to_fx (
    .sample (bus.eeg_data),
    .fx     (fx_p0)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (last_p0)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // A start outside IDLE is ignored, so the count only clears on a real launch.
      if (state_q == IDLE && bus.start)
        cnt_q <= '0;
      else if (accept_p0)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // p0 -> p1: registered memory write of the accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        wr_addr_p1 <= BASE + IntResAddr_t'(cnt_q);
        wr_data_p1 <= fx_p0;
      end
    end
  end

  assign bus.eeg_ready = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.wr_en     = vld_p1;
  assign bus.wr_addr   = wr_addr_p1;
  assign bus.wr_data   = wr_data_p1;
  assign bus.wr_width  = DOUBLE_WIDTH;

endmodule

// File: tb/tb_eeg_loader.sv
// Scoreboard bench for eeg_loader: randomized samples against a window-level reference model.
module tb_eeg_loader;
  import eeg_loader_pkg::*;

  localparam int N    = 3840;
  localparam int BASE = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eeg_loader_if bus();

  eeg_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          addr;
    logic [29:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  // Reference model: phase 0 = idle, 1 = collecting a window, 2 = window just completed.
  int  m_phase = 0;
  int  m_cnt   = 0;
  int  n_writes = 0;
  int  cyc = 0;
  bit  sparse_mode = 1'b0;
  int  last_wr_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [29:0] model_fx(input int d);
    int v;
`ifdef EEG_LOADER_MIDSCALE_OFFSET_EN
    v = (d - 32768) * 32;
`else
    v = d * 16;
`endif
    return v[29:0];
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard whenever a write or done is presented.
  wr_t mon_e;
  bit  mon_exp_done;
  always @(negedge clk) begin
    mon_exp_done = 1'b0;
    if (bus.wr_en === 1'b1) begin
      n_writes++;
      check("wr_width", bus.wr_width, DOUBLE_WIDTH);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", bus.wr_addr, 64'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, mon_e.addr);
        check("wr_data", $unsigned(bus.wr_data), mon_e.data);
        mon_exp_done = (mon_e.addr == BASE + N - 1);
      end
      if (sparse_mode && last_wr_cyc >= 0) check("sparse_gap", cyc - last_wr_cyc, 7);
      last_wr_cyc = cyc;
    end
    if (bus.wr_en === 1'b1 || bus.done === 1'b1)
      check("done_with_last_write", bus.done, mon_exp_done);
  end

  task automatic step(input bit s, input bit v, input logic [15:0] d);
    bit acc;
    bus.start     = s;
    bus.eeg_valid = v;
    bus.eeg_data  = d;
    check("eeg_ready", bus.eeg_ready, m_phase == 1);
    check("busy", bus.busy, m_phase != 0);
    acc = (m_phase == 1) && v;
    if (acc) begin
      exp_q.push_back('{BASE + m_cnt, model_fx(int'(d))});
      m_cnt++;
    end
    case (m_phase)
      0:       if (s) begin m_phase = 1; m_cnt = 0; end
      1:       if (acc && m_cnt == N) m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles, input bit v, input logic [15:0] d);
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.eeg_valid = v;
    bus.eeg_data  = d;
    repeat (cycles) @(posedge clk);
    #1;
    m_phase = 0;
    m_cnt   = 0;
    check("rst_eeg_ready", bus.eeg_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", $unsigned(bus.wr_data), 0);
    rst = 1'b0;
  endtask

  task automatic run_samples(input int count);
    for (int i = 0; i < count; i++) step(1'b0, 1'b1, 16'($urandom));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.eeg_valid = 1'b0;
    bus.eeg_data  = '0;

    // Reset with a sample offered: nothing may be written.
    do_reset(2, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 16'h1234);

    // Conversion corners then the rest of a full back-to-back window.
    n_writes = 0;
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b1, 16'h0000);
    run_samples(N - 3);
    step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, 16'h0000);
    check("full_window_writes", n_writes, N);

    // Sparse input: one valid every 7 cycles, then finish the window.
    n_writes = 0;
    step(1'b1, 1'b0, 16'h0000);
    sparse_mode = 1'b1;
    last_wr_cyc = -1;
    for (int i = 0; i < 7 * 30; i++) step(1'b0, (i % 7) == 0, 16'($urandom));
    sparse_mode = 1'b0;
    run_samples(N - 30);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    check("sparse_window_writes", n_writes, N);

    // Start reasserted mid-window and during DONE is ignored; DONE drops samples.
    n_writes = 0;
    step(1'b1, 1'b0, 16'h0000);
    run_samples(100);
    step(1'b1, 1'b1, 16'($urandom));
    step(1'b1, 1'b1, 16'($urandom));
    run_samples(N - 102);
    step(1'b1, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    check("restart_window_writes", n_writes, N);

    // Reset mid-window, then a fresh window starts at the base address.
    step(1'b1, 1'b0, 16'h0000);
    run_samples(2000);
    do_reset(1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b1, 16'($urandom));
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
